seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NDIGITS, default 8: number of multiplexed digits, 1..16.
REQ-002 SHALL have parameter SCAN_DIV_LOG2, default 18: each digit slot lasts 2^SCAN_DIV_LOG2 clocks, minimum 4.
REQ-003 SHALL have port CLK100MHZ  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port data  input  4*NDIGITS  hex nibbles; nibble i drives digit i, and digit 0 is the least significant.
REQ-006 SHALL have port dp  input  NDIGITS  decimal-point request per digit, 1 = lit.
REQ-007 SHALL have port blank  input  NDIGITS  force digit dark, 1 = dark.
REQ-008 SHALL have port load  input  1  one-cycle strobe that captures data/dp/blank into the pending register.
REQ-009 SHALL have port lz_en  input  1  enable leading-zero suppression.
REQ-010 SHALL have port bright  input  4  duty level; 15 = full on.
REQ-011 SHALL have port seg  output  7  segments g..a, active-low.
REQ-012 SHALL have port dp_n  output  1  decimal point, active-low.
REQ-013 SHALL have port an  output  NDIGITS  digit enables, active-low one-hot.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse per completed frame.

Function
REQ-015 SHALL run a free prescaler, pcnt, SCAN_DIV_LOG2 bits wide, that increments every clock and wraps to 0.
REQ-016 SHALL advance the digit index idx when pcnt wraps; idx goes 0..NDIGITS-1, then back to 0.
REQ-017 SHALL pulse frame_done for exactly one clock on the cycle in which idx goes from NDIGITS-1 to 0.
REQ-018 SHALL copy the pending register into the display register only on that wrap cycle, giving tear-free updates.
REQ-019 SHALL transfer the newly captured values directly when load coincides with the wrap cycle (bypass).
REQ-020 SHALL keep the last capture when load pulses several times within one frame.
REQ-021 SHALL encode nibbles with the team hex table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 SHALL, when lz_en=1, treat digit i (i>0) as suppressed if the display-register nibbles i..NDIGITS-1 are all zero; digit 0 is never suppressed.
REQ-023 SHALL light digit idx (an[idx]=0) only when it is not blanked, not suppressed, and the duty gate is open; all other an bits are 1.
REQ-024 SHALL drive seg=7'h7F and dp_n=1 while digit idx is dark; otherwise dp_n = ~dp[idx] from the display register.
REQ-025 SHALL register seg, dp_n and an, so they reflect idx and pcnt with one clock of latency.
REQ-026 SHALL ensure at most one an bit is low in any cycle, including across idx transitions.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force: pcnt=0, idx=0, pending and display registers = 0 with blank all-ones, seg=7'h7F, dp_n=1, an all ones, frame_done=0.
REQ-028 SHALL, when rst_n asserts mid-frame, abandon the frame without a frame_done pulse.
REQ-029 SHALL, after rst_n is released, start at digit 0 with the displays dark until the first load has been transferred.

Configuration
REQ-030 SHALL, with macro SEG_DIM_EN defined, open the duty gate when pcnt[SCAN_DIV_LOG2-1 -: 4] <= bright.
REQ-031 SHALL, with SEG_DIM_EN undefined, keep the duty gate always open, ignore bright, and synthesise no comparator.

Structure
REQ-032 SHALL place the 16-entry hex-to-segment table constant and the SEG_OFF constant (7'h7F) in shared package seg_pkg.
REQ-033 SHALL put the leading-zero mask computation in sub-module seg_lz_mask (input: nibble vector; output: suppress mask), which is purely combinational.

Verification
Bench parameters: NDIGITS=4, SCAN_DIV_LOG2=4.
REQ-034 SHALL cover frame timing: data=16'h1234, blank=0, load pulsed, lz_en=0, bright=15 -> an cycles 1110,1101,1011,0111 with 16 clocks per slot; seg shows 4,3,2,1 in slot order; frame_done pulses every 64 clocks.
REQ-035 SHALL cover tear-free update: load 16'hABCD at clock 10 of a frame -> the current frame still shows 1234, and the next frame shows D,C,B,A.
REQ-036 SHALL cover leading-zero suppression: data=16'h0005, lz_en=1 -> an[3:1] stay 1, digit 0 shows 0010010; data=16'h0000 -> only digit 0 lit, showing 1000000.
REQ-037 SHALL cover blank and decimal point: blank=4'b0100, dp=4'b0001 -> an[2] never 0, and dp_n=0 only during the digit 0 slot.
REQ-038 SHALL cover dimming with SEG_DIM_EN defined: bright=3 -> each an bit is low for 4 of its 16 slot clocks; bright=15 -> low for all 16.
REQ-039 SHALL cover reset mid-operation: rst_n low for 3 clocks mid-slot -> outputs reach reset values immediately, with no frame_done pulse.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants for the seven-segment scan driver: the
//               hex-to-segment glyph table (segments g..a, active-low) and
//               the all-dark segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // All segments off (active-low outputs).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Glyph table indexed by nibble value; bit 6 = g ... bit 0 = a, 0 = lit.
  // Entry 15 is listed first because the packed concatenation is MSB-first.
  localparam logic [15:0][6:0] c_hex_seg = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return c_hex_seg[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_lz_mask.sv
`default_nettype none
// ============================================================================
// Module      : seg_lz_mask
// Description : Purely combinational leading-zero mask. Digit i (i > 0) is
//               flagged when nibbles i..NDIGITS-1 are all zero; digit 0 is
//               never flagged so a zero value still shows a single "0".
// Ports       : nibbles  [4*NDIGITS-1:0] in  - packed hex nibbles, digit 0 LSB
//               suppress [NDIGITS-1:0]   out - 1 = digit is a leading zero
// Revision    : 1.0 - initial release
// ============================================================================
module seg_lz_mask #(
  parameter int NDIGITS = 8
) (
  input  logic [4*NDIGITS-1:0] nibbles,
  output logic [NDIGITS-1:0]   suppress
);

  // Digit 0's own nibble never influences the mask.
  logic w_unused_lsd;
  assign w_unused_lsd = ^nibbles[3:0];

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign suppress[gi] = 1'b0;
      end else begin : g_upper
        // Everything from this digit up to the most significant is zero.
        assign suppress[gi] = (nibbles[4*NDIGITS-1 : 4*gi] == '0);
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed seven-segment scan driver. A free-running
//               prescaler defines one slot per digit; a double-buffered
//               (pending -> display) register set gives tear-free updates at
//               frame boundaries. Supports per-digit blanking, decimal points
//               and leading-zero suppression.
// Options     : SEG_DIM_EN - when defined, a duty gate compares the top four
//               prescaler bits against 'bright' to dim the display. When
//               undefined the gate is always open and 'bright' is ignored.
// Ports       : CLK100MHZ   in  - clock, rising edge
//               rst_n       in  - asynchronous reset, active-low
//               data        in  - 4*NDIGITS hex nibbles, digit 0 least significant
//               dp          in  - decimal point request per digit, 1 = lit
//               blank       in  - force digit dark, 1 = dark
//               load        in  - one-cycle capture strobe into pending register
//               lz_en       in  - enable leading-zero suppression
//               bright      in  - duty level, 15 = full on
//               seg         out - segments g..a, active-low (registered)
//               dp_n        out - decimal point, active-low (registered)
//               an          out - digit enables, active-low one-hot (registered)
//               frame_done  out - one-cycle pulse on the frame wrap cycle
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NDIGITS       = 8,
  parameter int SCAN_DIV_LOG2 = 18
) (
  input  logic                   CLK100MHZ,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  input  logic                   load,
  input  logic                   lz_en,
  input  logic [3:0]             bright,
  output logic [6:0]             seg,
  output logic                   dp_n,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_done
);

  localparam int                 c_idx_w    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NDIGITS - 1);

  // Scan position
  logic [SCAN_DIV_LOG2-1:0] r_pcnt;
  logic [c_idx_w-1:0]       r_idx;

  // Pending (written by load) and display (shown) register sets
  logic [4*NDIGITS-1:0]     r_pend_data, r_disp_data;
  logic [NDIGITS-1:0]       r_pend_dp,   r_disp_dp;
  logic [NDIGITS-1:0]       r_pend_blank, r_disp_blank;

  // Registered outputs
  logic [6:0]               r_seg;
  logic                     r_dp_n;
  logic [NDIGITS-1:0]       r_an;

  logic                     w_pcnt_wrap;
  logic                     w_frame_wrap;
  logic                     w_gate;
  logic                     w_dark;
  logic [3:0]               w_nib;
  logic [NDIGITS-1:0]       w_sup;

  assign w_pcnt_wrap  = &r_pcnt;
  assign w_frame_wrap = w_pcnt_wrap && (r_idx == c_last_idx);

  // ---------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
      if (w_pcnt_wrap) begin
        r_idx <= w_frame_wrap ? '0 : r_idx + c_idx_w'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer. The display set only changes on the frame wrap cycle; a
  // load landing on that same cycle is forwarded straight through so it is
  // not held back a whole frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '1;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '1;
    end else begin
      if (load) begin
        r_pend_data  <= data;
        r_pend_dp    <= dp;
        r_pend_blank <= blank;
      end
      if (w_frame_wrap) begin
        r_disp_data  <= load ? data  : r_pend_data;
        r_disp_dp    <= load ? dp    : r_pend_dp;
        r_disp_blank <= load ? blank : r_pend_blank;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask on the displayed value
  // ---------------------------------------------------------------------------
  seg_lz_mask #(
    .NDIGITS (NDIGITS)
  ) u_lz_mask (
    .nibbles  (r_disp_data),
    .suppress (w_sup)
  );

  // ---------------------------------------------------------------------------
  // Duty gate
  // ---------------------------------------------------------------------------
`ifdef SEG_DIM_EN
  assign w_gate = (r_pcnt[SCAN_DIV_LOG2-1 -: 4] <= bright);
`else
  logic w_unused_bright;
  assign w_unused_bright = ^bright;
  assign w_gate          = 1'b1;
`endif

  assign w_nib  = r_disp_data[4*r_idx +: 4];
  assign w_dark = r_disp_blank[r_idx] | (lz_en & w_sup[r_idx]) | ~w_gate;

  // ---------------------------------------------------------------------------
  // Output registers. The anode vector is rebuilt from scratch every cycle
  // from a single index, so at most one bit can ever be low, including
  // across slot changes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_seg  <= SEG_OFF;
      r_dp_n <= 1'b1;
      r_an   <= '1;
    end else if (w_dark) begin
      r_seg  <= SEG_OFF;
      r_dp_n <= 1'b1;
      r_an   <= '1;
    end else begin
      r_seg  <= hex_to_seg(w_nib);
      r_dp_n <= ~r_disp_dp[r_idx];
      r_an   <= ~(NDIGITS'(1) << r_idx);
    end
  end

  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign an         = r_an;
  assign frame_done = w_frame_wrap;

endmodule
`default_nettype wire
